// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder slice.
//   FFT_DW / FFT_N / FFT_LOGN : sample width, frame length, index width
//   sample_t                  : one complex sample {re, im}
//   rd_state_t                : read-side FSM states
//   bitrev()                  : FFT_LOGN-bit index reversal
package fft_pkg;

    localparam int FFT_DW   = 17;
    localparam int FFT_N    = 32;
    localparam int FFT_LOGN = 5;

    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] im;
    } sample_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    function automatic logic [FFT_LOGN-1:0] bitrev(input logic [FFT_LOGN-1:0] idx);
        logic [FFT_LOGN-1:0] r;
        for (int b = 0; b < FFT_LOGN; b++) begin
            r[b] = idx[FFT_LOGN-1-b];
        end
        return r;
    endfunction

endpackage

// File: rtl/reorder_bank.sv
// One N-entry bank of the reorder double buffer.
//   clk   : rising-edge clock
//   we    : write enable, writes wdata to mem[waddr] on the clock edge
//   waddr : write address
//   wdata : packed {re, im} sample
//   raddr : read address (combinational read)
//   rdata : mem[raddr]
// Contents are not reset; a bank is only read after it has been fully written.
module reorder_bank #(
    parameter int DW   = 17,
    parameter int N    = 32,
    parameter int LOGN = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [LOGN-1:0]   waddr,
    input  logic [2*DW-1:0]   wdata,
    input  logic [LOGN-1:0]   raddr,
    output logic [2*DW-1:0]   rdata
);

    logic [2*DW-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_out_reorder.sv
// Output reorder buffer for the 32-point FFT. Samples arrive in bit-reversed
// order; each frame is written to one of two banks at its natural index and
// read back out in natural order 0..N-1 while the other bank fills.
//   clk        : rising-edge clock
//   rst        : asynchronous reset, active low
//   valid_i    : input sample valid (one sample per asserted cycle)
//   data_in_r  : input real part, signed
//   data_in_i  : input imaginary part, signed
//   valid_o    : output sample valid
//   data_out_r : output real part, signed
//   data_out_i : output imaginary part, signed
//   index_o    : natural-order bin index of the current output
//   err_o      : sticky overflow flag (sample arrived with no free bank)
module fft_out_reorder
    import fft_pkg::*;
#(
    parameter int DW   = FFT_DW,
    parameter int N    = FFT_N,
    parameter int LOGN = FFT_LOGN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic signed [DW-1:0] data_in_r,
    input  logic signed [DW-1:0] data_in_i,
    output logic                 valid_o,
    output logic signed [DW-1:0] data_out_r,
    output logic signed [DW-1:0] data_out_i,
    output logic [LOGN-1:0]      index_o,
    output logic                 err_o
);

    localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

    logic [LOGN-1:0] wcnt;
    logic [LOGN-1:0] rcnt;
    logic            wbank;
    logic            rbank;
    logic [1:0]      full;
    logic [1:0]      full_set;
    logic [1:0]      full_clr;
    logic [1:0]      bank_we;
    logic            wr_open;
    logic            wr_en;
    logic            ovf;
    rd_state_t       rd_state;

    sample_t         wword;
    sample_t         rword;
    logic [2*DW-1:0] rword0;
    logic [2*DW-1:0] rword1;
    logic [LOGN-1:0] waddr;

    // Bank bookkeeping. The reader frees a bank on the same edge that it
    // issues index N-1; at full input rate the next frame's first sample
    // lands on that very edge, so a bank being released counts as open.
    // Its first write goes to address bitrev(0)=0 while the reader is on N-1.
    always_comb begin
        full_clr        = '0;
        full_set        = '0;
        bank_we         = '0;
        full_clr[rbank] = (rd_state == RD_READ) && (rcnt == LAST);
        wr_open         = !full[wbank] || full_clr[wbank];
        wr_en           = valid_i && wr_open;
        full_set[wbank] = wr_en && (wcnt == LAST);
        bank_we[wbank]  = wr_en;
        ovf             = (valid_i && !wr_open) || (|(full_set & full_clr));
    end

    assign wword = '{re: data_in_r, im: data_in_i};
    assign waddr = bitrev(wcnt);
    assign rword = rbank ? rword1 : rword0;

    reorder_bank #(.DW(DW), .N(N), .LOGN(LOGN)) u_bank0 (
        .clk   (clk),
        .we    (bank_we[0]),
        .waddr (waddr),
        .wdata (wword),
        .raddr (rcnt),
        .rdata (rword0)
    );

    reorder_bank #(.DW(DW), .N(N), .LOGN(LOGN)) u_bank1 (
        .clk   (clk),
        .we    (bank_we[1]),
        .waddr (waddr),
        .wdata (wword),
        .raddr (rcnt),
        .rdata (rword1)
    );

    // Write side: counts accepted samples, flips banks at end of frame.
    // A set and a clear of the same full bit on one edge resolve to set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt  <= '0;
            wbank <= 1'b0;
            full  <= '0;
            err_o <= 1'b0;
        end else begin
            full <= (full & ~full_clr) | full_set;
            if (ovf) begin
                err_o <= 1'b1;
            end
            if (wr_en) begin
                if (wcnt == LAST) begin
                    wcnt  <= '0;
                    wbank <= ~wbank;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
        end
    end

    // Read side: IDLE waits for a full bank, READ streams it in natural order
    // and chains directly into the other bank if it is already full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state   <= RD_IDLE;
            rcnt       <= '0;
            rbank      <= 1'b0;
            valid_o    <= 1'b0;
            data_out_r <= '0;
            data_out_i <= '0;
            index_o    <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    valid_o <= 1'b0;
                    if (full[rbank]) begin
                        rd_state <= RD_READ;
                        rcnt     <= '0;
                    end
                end
                RD_READ: begin
                    valid_o    <= 1'b1;
                    data_out_r <= rword.re;
                    data_out_i <= rword.im;
                    index_o    <= rcnt;
                    if (rcnt == LAST) begin
                        rcnt  <= '0;
                        rbank <= ~rbank;
                        if (!full[~rbank]) begin
                            rd_state <= RD_IDLE;
                        end
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed testbench for fft_out_reorder: reset state, single frame,
// gapped input, three back-to-back frames, 17-bit extremes, overflow with
// the reader held off, and reset in the middle of a frame.
module tb_fft_out_reorder;
    import fft_pkg::*;

    logic               clk;
    logic               rst;
    logic               valid_i;
    logic signed [16:0] data_in_r;
    logic signed [16:0] data_in_i;
    logic               valid_o;
    logic signed [16:0] data_out_r;
    logic signed [16:0] data_out_i;
    logic [4:0]         index_o;
    logic               err_o;

    int n_cmp = 0;
    int n_bad = 0;

    fft_out_reorder dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .data_in_r  (data_in_r),
        .data_in_i  (data_in_i),
        .valid_o    (valid_o),
        .data_out_r (data_out_r),
        .data_out_i (data_out_i),
        .index_o    (index_o),
        .err_o      (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    function automatic int br5(input int x);
        int r;
        r = 0;
        for (int b = 0; b < 5; b++) begin
            if (((x >> b) & 1) == 1) r = r | (1 << (4 - b));
        end
        return r;
    endfunction

    // Applies one input cycle just after a rising edge; it is captured on the
    // following rising edge (which the next drive call waits for).
    task automatic drive(input logic v, input int re, input int im);
        @(posedge clk);
        #1;
        valid_i   = v;
        data_in_r = 17'(re);
        data_in_i = 17'(im);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        valid_i = 1'b0;
        data_in_r = '0;
        data_in_i = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_cmp++; if (index_o !== 5'd0) begin n_bad++; $display("FAIL reset_index: got %0d want 0", index_o); end
        n_cmp++; if (data_out_r !== 17'sd0) begin n_bad++; $display("FAIL reset_re: got %0d want 0", data_out_r); end
        n_cmp++; if (data_out_i !== 17'sd0) begin n_bad++; $display("FAIL reset_im: got %0d want 0", data_out_i); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_o); end
        rst = 1'b1;
        repeat (3) step();
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_idle_valid: got %b want 0", valid_o); end
    endtask

    task automatic test_single();
        int c;
        for (int p = 0; p < 32; p++) drive(1'b1, br5(p), -br5(p));
        drive(1'b0, 0, 0);
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL single_early: got valid %b want 0", valid_o); end
        c = 0;
        while (valid_o !== 1'b1 && c < 40) begin step(); c++; end
        n_cmp++; if (c != 2) begin n_bad++; $display("FAIL single_latency: got %0d cycles want 2", c); end
        for (int j = 0; j < 32; j++) begin
            if (j > 0) step();
            n_cmp++;
            if (valid_o !== 1'b1 || index_o !== 5'(j) || data_out_r !== 17'(j) || data_out_i !== 17'(-j)) begin
                n_bad++;
                $display("FAIL single[%0d]: got v=%b idx=%0d re=%0d im=%0d, want v=1 idx=%0d re=%0d im=%0d",
                         j, valid_o, index_o, data_out_r, data_out_i, j, j, -j);
            end
        end
        step();
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL single_fall: got valid %b want 0", valid_o); end
    endtask

    task automatic test_gapped();
        int c;
        for (int p = 0; p < 32; p++) begin
            drive(1'b1, br5(p), -br5(p));
            drive(1'b0, 999, -999);
        end
        c = 0;
        while (valid_o !== 1'b1 && c < 40) begin step(); c++; end
        n_cmp++; if (c != 2) begin n_bad++; $display("FAIL gapped_latency: got %0d cycles want 2", c); end
        for (int j = 0; j < 32; j++) begin
            if (j > 0) step();
            n_cmp++;
            if (valid_o !== 1'b1 || index_o !== 5'(j) || data_out_r !== 17'(j) || data_out_i !== 17'(-j)) begin
                n_bad++;
                $display("FAIL gapped[%0d]: got v=%b idx=%0d re=%0d im=%0d, want v=1 idx=%0d re=%0d im=%0d",
                         j, valid_o, index_o, data_out_r, data_out_i, j, j, -j);
            end
        end
        step();
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL gapped_fall: got valid %b want 0", valid_o); end
    endtask

    task automatic test_back_to_back();
        int c;
        fork
            begin
                for (int p = 0; p < 96; p++)
                    drive(1'b1, 32 * (p / 32) + br5(p % 32), -(32 * (p / 32) + br5(p % 32)));
                drive(1'b0, 0, 0);
            end
            begin
                c = 0;
                step();
                while (valid_o !== 1'b1 && c < 200) begin step(); c++; end
                n_cmp++; if (c >= 200) begin n_bad++; $display("FAIL b2b_start: got no valid_o within %0d cycles want rise", c); end
                for (int j = 0; j < 96; j++) begin
                    if (j > 0) step();
                    n_cmp++;
                    if (valid_o !== 1'b1 || index_o !== 5'(j % 32) || data_out_r !== 17'(j) || data_out_i !== 17'(-j)) begin
                        n_bad++;
                        $display("FAIL b2b[%0d]: got v=%b idx=%0d re=%0d im=%0d, want v=1 idx=%0d re=%0d im=%0d",
                                 j, valid_o, index_o, data_out_r, data_out_i, j % 32, j, -j);
                    end
                end
                step();
                n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_fall: got valid %b want 0", valid_o); end
                n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL b2b_err: got %b want 0", err_o); end
            end
        join
    endtask

    task automatic test_extremes();
        int c;
        int er;
        int ei;
        for (int p = 0; p < 32; p++) begin
            er = (br5(p) % 2 == 0) ? 65535 : -65536;
            ei = (br5(p) % 2 == 0) ? -65536 : 65535;
            drive(1'b1, er, ei);
        end
        drive(1'b0, 0, 0);
        c = 0;
        while (valid_o !== 1'b1 && c < 40) begin step(); c++; end
        n_cmp++; if (c != 2) begin n_bad++; $display("FAIL ext_latency: got %0d cycles want 2", c); end
        for (int j = 0; j < 32; j++) begin
            if (j > 0) step();
            er = (j % 2 == 0) ? 65535 : -65536;
            ei = (j % 2 == 0) ? -65536 : 65535;
            n_cmp++;
            if (valid_o !== 1'b1 || index_o !== 5'(j) || data_out_r !== 17'(er) || data_out_i !== 17'(ei)) begin
                n_bad++;
                $display("FAIL ext[%0d]: got v=%b idx=%0d re=%0d im=%0d, want v=1 idx=%0d re=%0d im=%0d",
                         j, valid_o, index_o, data_out_r, data_out_i, j, er, ei);
            end
        end
        step();
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL ext_fall: got valid %b want 0", valid_o); end
    endtask

    task automatic test_overflow();
        int c;
        int er;
        force dut.rd_state = RD_IDLE;
        for (int p = 0; p < 64; p++)
            drive(1'b1, 300 + 100 * (p / 32) + br5(p % 32), -(300 + 100 * (p / 32) + br5(p % 32)));
        drive(1'b1, 777, -777);
        drive(1'b0, 0, 0);
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL ovf_err: got %b want 1", err_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL ovf_hold: got valid %b want 0", valid_o); end
        release dut.rd_state;
        c = 0;
        while (valid_o !== 1'b1 && c < 40) begin step(); c++; end
        n_cmp++; if (c >= 40) begin n_bad++; $display("FAIL ovf_start: got no valid_o within %0d cycles want rise", c); end
        for (int j = 0; j < 64; j++) begin
            if (j > 0) step();
            er = 300 + 100 * (j / 32) + (j % 32);
            n_cmp++;
            if (valid_o !== 1'b1 || index_o !== 5'(j % 32) || data_out_r !== 17'(er) || data_out_i !== 17'(-er)) begin
                n_bad++;
                $display("FAIL ovf_out[%0d]: got v=%b idx=%0d re=%0d im=%0d, want v=1 idx=%0d re=%0d im=%0d",
                         j, valid_o, index_o, data_out_r, data_out_i, j % 32, er, -er);
            end
        end
        step();
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL ovf_fall: got valid %b want 0", valid_o); end
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", err_o); end
    endtask

    task automatic test_reset_mid_frame();
        int c;
        for (int p = 0; p < 10; p++) drive(1'b1, 500 + p, 600 + p);
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid_i = 1'b0;
        #2;
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", valid_o); end
        n_cmp++; if (index_o !== 5'd0) begin n_bad++; $display("FAIL mid_rst_index: got %0d want 0", index_o); end
        n_cmp++; if (data_out_r !== 17'sd0) begin n_bad++; $display("FAIL mid_rst_re: got %0d want 0", data_out_r); end
        n_cmp++; if (data_out_i !== 17'sd0) begin n_bad++; $display("FAIL mid_rst_im: got %0d want 0", data_out_i); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_err: got %b want 0", err_o); end
        repeat (2) step();
        rst = 1'b1;
        for (int p = 0; p < 32; p++) drive(1'b1, 3 * br5(p) + 1, -2 * br5(p));
        drive(1'b0, 0, 0);
        c = 0;
        while (valid_o !== 1'b1 && c < 40) begin step(); c++; end
        n_cmp++; if (c != 2) begin n_bad++; $display("FAIL mid_latency: got %0d cycles want 2", c); end
        for (int j = 0; j < 32; j++) begin
            if (j > 0) step();
            n_cmp++;
            if (valid_o !== 1'b1 || index_o !== 5'(j) || data_out_r !== 17'(3 * j + 1) || data_out_i !== 17'(-2 * j)) begin
                n_bad++;
                $display("FAIL mid_out[%0d]: got v=%b idx=%0d re=%0d im=%0d, want v=1 idx=%0d re=%0d im=%0d",
                         j, valid_o, index_o, data_out_r, data_out_i, j, 3 * j + 1, -2 * j);
            end
        end
        step();
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL mid_fall: got valid %b want 0", valid_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL mid_err: got %b want 0", err_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gapped();
        test_back_to_back();
        test_extremes();
        test_overflow();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
